adder_pipe: RTL and testbench

//  Pipelined 64-bit two's-complement adder: the inverse of the ALU subtractor (dif + b recovers a).

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_add_slice.sv | 23 ++
 rtl/adder_pipe.sv | 129 ++++++++++++
 tb/tb_adder_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU word and slice constants
package alu_pkg;

    // Datapath word width shared by every ALU unit
    localparam int ALU_WORD_W = 64;

    // Bits resolved per pipeline stage in the carry-chained adder
    localparam int ALU_ADD_SLICE = 16;

endpackage

// File: rtl/alu_add_slice.sv
// rtl/alu_add_slice.sv - combinational W-bit adder slice exposing carry into its MSB
module alu_add_slice
    import alu_pkg::*;
#(
    parameter int W = ALU_ADD_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    // Sum of the low W-1 bits; its top bit is the carry into the slice MSB
    logic [W-1:0] low;

    assign low   = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
    assign c_msb = low[W-1];
    assign s     = {a[W-1] ^ b[W-1] ^ c_msb, low[W-2:0]};
    assign co    = (a[W-1] & b[W-1]) | (c_msb & (a[W-1] ^ b[W-1]));

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined two's-complement adder, one slice per stage
module adder_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WORD_W,
    parameter int SLICE = ALU_ADD_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE;

    logic              advance;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;

    // Global stall: the whole pipe moves only when the output slot is free or being drained
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];

    // Valid bits shift with the pipe; an idle input enters as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (advance) begin
            v_q <= {v_q[STAGES-2:0], in_valid};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO_W = (k + 1) * SLICE;

        logic [SLICE-1:0] sa;
        logic [SLICE-1:0] sb;
        logic [SLICE-1:0] ss;
        logic             ci;
        logic             co;
        logic             cm;
        logic [LO_W-1:0]  sum_d;
        logic [LO_W-1:0]  sum_q;
        logic             c_q;

        if (k == 0) begin : g_first
            assign sa    = a[SLICE-1:0];
            assign sb    = b[SLICE-1:0];
            assign ci    = cin;
            assign sum_d = ss;
        end else begin : g_next
            assign sa    = stg[k-1].g_skew.a_hi_q[SLICE-1:0];
            assign sb    = stg[k-1].g_skew.b_hi_q[SLICE-1:0];
            assign ci    = stg[k-1].c_q;
            assign sum_d = {ss, stg[k-1].sum_q};
        end

        alu_add_slice #(.W(SLICE)) u_slice (
            .a     (sa),
            .b     (sb),
            .ci    (ci),
            .s     (ss),
            .co    (co),
            .c_msb (cm)
        );

        // Carry to the next stage and the growing deskewed low part of the result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                c_q   <= co;
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            localparam int HI_W = WIDTH - LO_W;

            logic [HI_W-1:0] a_hi_d;
            logic [HI_W-1:0] b_hi_d;
            logic [HI_W-1:0] a_hi_q;
            logic [HI_W-1:0] b_hi_q;

            if (k == 0) begin : g_src
                assign a_hi_d = a[WIDTH-1:SLICE];
                assign b_hi_d = b[WIDTH-1:SLICE];
            end else begin : g_src
                assign a_hi_d = stg[k-1].g_skew.a_hi_q[HI_W+SLICE-1:SLICE];
                assign b_hi_d = stg[k-1].g_skew.b_hi_q[HI_W+SLICE-1:SLICE];
            end

            // Operand slices not yet added ride along until their stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (advance) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end
    end

    // Signed overflow registered alongside the final sum and carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= stg[STAGES-1].cm ^ stg[STAGES-1].co;
        end
    end

    assign sum  = stg[STAGES-1].sum_q;
    assign cout = stg[STAGES-1].c_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed self-checking bench for adder_pipe
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [63:0] av, input logic [63:0] bv,
                           input logic ci, input logic [63:0] es, input logic ec, input logic eo);
        int n;
        a         = av;
        b         = bv;
        cin       = ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n         = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 20);
        chk({tag, " latency"}, 64'(n), 64'd4);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, {63'd0, cout}, {63'd0, ec});
        chk({tag, " ovf"}, {63'd0, ovf}, {63'd0, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [63:0] ia;
        logic signed [63:0] ib;
        int sent;
        int recv;
        int n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset sum", sum, 64'd0);
        chk("reset cout", {63'd0, cout}, 64'd0);
        chk("reset ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        run_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
        run_one("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_one("neg_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_one("slice_carry", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0,
                64'h0000_FFFF_0001_0000, 1'b0, 1'b0);
        ia = 64'sd2036854775808;
        ib = -64'sd9223372036854;
        run_one("inverse", ia - ib, ib, 1'b0, ia, 1'b1, 1'b0);

        sent = 0;
        recv = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 6);
            a         = 64'(sent + 1);
            b         = 64'(sent + 1) << 32;
            cin       = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                chk("bp in_ready held low", {63'd0, in_ready}, 64'd0);
            end
            if (out_valid) begin
                if (recv < 6) begin
                    chk("bp sum order", sum, (64'(recv + 1) << 32) | 64'(recv + 1));
                end else begin
                    chk("bp extra result", {63'd0, out_valid}, 64'd0);
                end
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp sent count", 64'(sent), 64'd6);
        chk("bp recv count", 64'(recv), 64'd6);

        for (int i = 0; i < 4; i++) begin
            a        = 64'(100 + i);
            b        = 64'd1;
            cin      = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rst pre out_valid", {63'd0, out_valid}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid drop", {63'd0, out_valid}, 64'd0);
        chk("rst sum clear", sum, 64'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) n++;
        end
        chk("rst no stale result", 64'(n), 64'd0);
        run_one("post_reset", 64'd12345, 64'd55, 1'b1, 64'd12401, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
